// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage program counter with boot bubble, stall hold,
// stall-deferred redirects and a misaligned-branch-target trap.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h100,
    parameter int              PC_INCREMENT = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_enable,
    input  logic [XLEN-1:0] branch_address,
    input  logic            trap_enable,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            misaligned_fault,
    output logic [XLEN-1:0] fault_address
);

    typedef enum logic {BOOT, RUN} state_t;

    // Mask of target bits that must be zero; ALIGN_BITS=0 yields an empty mask,
    // which disables the misalignment check without a zero-width slice.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;
    logic            pend_nxt;
    logic            fault_nxt;
    logic [XLEN-1:0] fault_addr_nxt;
    logic            misaligned;

    assign misaligned  = |(branch_address & ALIGN_MASK);
    assign pc_next_seq = pc + XLEN'(PC_INCREMENT);
    assign pc_valid    = (state == RUN);

    // State and datapath registers; reset discards any pending redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= BOOT;
            pc               <= RESET_VECTOR;
            pend_tgt         <= '0;
            redirect_pending <= 1'b0;
            misaligned_fault <= 1'b0;
            fault_address    <= '0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            pend_tgt         <= pend_tgt_nxt;
            redirect_pending <= pend_nxt;
            misaligned_fault <= fault_nxt;
            fault_address    <= fault_addr_nxt;
        end
    end

    // Next-state: BOOT ignores inputs for one edge; RUN applies redirect priority.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_tgt_nxt   = pend_tgt;
        pend_nxt       = redirect_pending;
        fault_nxt      = 1'b0;
        fault_addr_nxt = fault_address;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                pc_nxt    = RESET_VECTOR;
            end
            RUN: begin
                if (trap_enable) begin
                    pc_nxt   = TRAP_VECTOR;
                    pend_nxt = 1'b0;
                end else if (branch_enable && misaligned) begin
                    pc_nxt         = TRAP_VECTOR;
                    fault_nxt      = 1'b1;
                    fault_addr_nxt = branch_address;
                    pend_nxt       = 1'b0;
                end else if (stall) begin
                    // Hold pc; a newer branch replaces any older pending target.
                    if (branch_enable) begin
                        pend_tgt_nxt = branch_address;
                        pend_nxt     = 1'b1;
                    end
                end else if (branch_enable) begin
                    pc_nxt   = branch_address;
                    pend_nxt = 1'b0;
                end else if (redirect_pending) begin
                    pc_nxt   = pend_tgt;
                    pend_nxt = 1'b0;
                end else begin
                    pc_nxt = pc_next_seq;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the sequencer's rules.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP = 32'h100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_enable = 1'b0;
    logic [31:0] branch_address = '0;
    logic        trap_enable = 1'b0;
    logic [31:0] pc, pc_next_seq, fault_address;
    logic        pc_valid, redirect_pending, misaligned_fault;

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [31:0] m_pc, m_tgt, m_faddr;
    logic        m_booting, m_pend, m_fault;

    pc_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .branch_enable    (branch_enable),
        .branch_address   (branch_address),
        .trap_enable      (trap_enable),
        .pc               (pc),
        .pc_next_seq      (pc_next_seq),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .misaligned_fault (misaligned_fault),
        .fault_address    (fault_address)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_faddr = 32'h0;
        m_booting = 1'b1; m_pend = 1'b0; m_fault = 1'b0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_edge();
        logic mis;
        if (!reset) begin
            model_reset();
            return;
        end
        mis = (branch_address % 4) != 0;
        m_fault = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (trap_enable) begin
            m_pc = TRAP; m_pend = 1'b0;
        end else if (branch_enable && mis) begin
            m_pc = TRAP; m_pend = 1'b0; m_fault = 1'b1; m_faddr = branch_address;
        end else if (stall) begin
            if (branch_enable) begin m_tgt = branch_address; m_pend = 1'b1; end
        end else if (branch_enable) begin
            m_pc = branch_address; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("pc_next_seq", pc_next_seq, m_pc + 32'd4);
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, !m_booting});
        chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
        chk("misaligned_fault", {31'b0, misaligned_fault}, {31'b0, m_fault});
        chk("fault_address", fault_address, m_faddr);
    endtask

    // Advance one clock; model tracks the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_model();
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] a, input logic t);
        stall = s; branch_enable = b; branch_address = a; trap_enable = t;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        // reset state
        check_model();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);

        // T1 boot
        reset = 1'b1;
        #1 chk("t1_boot_valid", {31'b0, pc_valid}, 32'h0);
        step(); chk("t1_pc0", pc, 32'h0); chk("t1_valid", {31'b0, pc_valid}, 32'h1);
        step(); chk("t1_pc4", pc, 32'h4);
        step(); chk("t1_pc8", pc, 32'h8);

        // T2 branch
        drive(0, 1, 32'h100, 0); step(); chk("t2_pc100", pc, 32'h100);
        drive(0, 0, 0, 0);       step(); chk("t2_pc104", pc, 32'h104);

        // T3 deferred redirect
        drive(1, 1, 32'h200, 0); step(); chk("t3_hold", pc, 32'h104);
        chk("t3_pend", {31'b0, redirect_pending}, 32'h1);
        drive(1, 0, 0, 0); step(); step();
        chk("t3_hold3", pc, 32'h104);
        chk("t3_pend3", {31'b0, redirect_pending}, 32'h1);
        drive(0, 0, 0, 0); step(); chk("t3_pc200", pc, 32'h200);
        chk("t3_pend_clr", {31'b0, redirect_pending}, 32'h0);

        // T4 misaligned
        drive(0, 1, 32'h102, 0); step(); chk("t4_trap", pc, 32'h100);
        chk("t4_fault", {31'b0, misaligned_fault}, 32'h1);
        chk("t4_faddr", fault_address, 32'h102);
        drive(0, 0, 0, 0); step();
        chk("t4_fault_drop", {31'b0, misaligned_fault}, 32'h0);
        chk("t4_faddr_hold", fault_address, 32'h102);
        chk("t4_pc104", pc, 32'h104);

        // T5 trap beats stall, branch and pending
        drive(1, 1, 32'h300, 0); step();
        chk("t5_pend", {31'b0, redirect_pending}, 32'h1);
        drive(1, 1, 32'h400, 1); step();
        chk("t5_trap", pc, 32'h100);
        chk("t5_pend_clr", {31'b0, redirect_pending}, 32'h0);
        drive(0, 0, 0, 0); step(); chk("t5_after", pc, 32'h104);

        // T6 wrap and async reset between edges
        drive(0, 1, 32'hFFFF_FFFC, 0); step(); chk("t6_top", pc, 32'hFFFF_FFFC);
        chk("t6_nseq_wrap", pc_next_seq, 32'h0);
        drive(0, 0, 0, 0); step(); chk("t6_wrap", pc, 32'h0);
        drive(1, 1, 32'h500, 0); step();
        #2 reset = 1'b0; model_reset();
        #1 chk("t6_arst_pc", pc, 32'h0);
        chk("t6_arst_valid", {31'b0, pc_valid}, 32'h0);
        chk("t6_arst_pend", {31'b0, redirect_pending}, 32'h0);
        chk("t6_arst_faddr", fault_address, 32'h0);
        check_model();
        drive(0, 0, 0, 0);
        @(negedge clock); reset = 1'b1;

        // randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                default: a = $urandom & 32'h0000_FFFC;
            endcase
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, a,
                  $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0; model_reset();
                #1 check_model();
            end else if (!reset) begin
                reset = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
